// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding,
// FSM state type and the size-to-byte-count helper.
`timescale 1ns/1ps
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_BYTE: n = 4'd1;
      SZ_HALF: n = 4'd2;
      SZ_WORD: n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane steering for the load/store unit. The addressed byte always
// sits in the MSB lane of the doubleword read at that address, so a load takes
// the top n bytes and a store replaces the top n bytes.
`timescale 1ns/1ps
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_store_data
);

  logic w_fill;

  // Extension bit: result MSB for signed sub-doubleword loads, else zero.
  assign w_fill = i_signed & i_rd_data[63];

  // Load extract/extend and store byte-merge per access size.
  always_comb begin
    o_load_data  = i_rd_data;
    o_store_data = i_wr_data;
    case (i_size)
      SZ_BYTE: begin
        o_load_data  = {{56{w_fill}}, i_rd_data[63:56]};
        o_store_data = {i_wr_data[7:0], i_rd_data[55:0]};
      end
      SZ_HALF: begin
        o_load_data  = {{48{w_fill}}, i_rd_data[63:48]};
        o_store_data = {i_wr_data[15:0], i_rd_data[47:0]};
      end
      SZ_WORD: begin
        o_load_data  = {{32{w_fill}}, i_rd_data[63:32]};
        o_store_data = {i_wr_data[31:0], i_rd_data[31:0]};
      end
      default: begin
        o_load_data  = i_rd_data;
        o_store_data = i_wr_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory register and a 64-bit
// big-endian byte-addressed data memory. One request in flight; sub-doubleword
// stores are read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN turns
// misaligned accesses into errors.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_address,
  input  logic [DATA_W-1:0] i_req_write_data,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_resp_error,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_memory_read,
  output logic              o_memory_write,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_size;
  logic              r_write;
  logic              r_signed;
  logic              r_err;

  logic              w_accept;
  logic              w_err;
  logic [3:0]        w_req_n;
  logic [ADDR_W:0]   w_end;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_store;

  assign w_accept = i_req_valid & (r_state == ST_IDLE);
  assign w_req_n  = size_bytes(i_req_size);

  // One extra bit so an address that wraps past the top is still out of range.
  assign w_end = {1'b0, i_req_address} + (ADDR_W+1)'(w_req_n);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = (w_end > (ADDR_W+1)'(MEM_SIZE)) ||
                 ((i_req_address[2:0] & (w_req_n[2:0] - 3'd1)) != 3'd0);
`else
  assign w_err = (w_end > (ADDR_W+1)'(MEM_SIZE));
`endif

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_rd_data    (r_rdata),
    .i_wr_data    (r_wdata),
    .o_load_data  (w_load),
    .o_store_data (w_store)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Request capture on acceptance and read-data capture at the end of WT.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_addr   <= i_req_address;
      r_wdata  <= i_req_write_data;
      r_size   <= i_req_size;
      r_write  <= i_req_write;
      r_signed <= i_req_signed;
      r_err    <= w_err;
    end
    if (r_state == ST_WT) r_rdata <= i_mem_read_data;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err)                                  w_next = ST_RESP;
          else if (i_req_write && i_req_size == SZ_DWORD) w_next = ST_WR;
          else                                        w_next = ST_RD;
        end
      end
      ST_RD:   w_next = ST_WT;
      ST_WT:   w_next = r_write ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: if (i_resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory strobes are masked by reset so a reset
  // raised during WR keeps that edge from writing.
  always_comb begin
    o_req_ready      = (r_state == ST_IDLE);
    o_resp_valid     = (r_state == ST_RESP);
    o_resp_error     = (r_state == ST_RESP) & r_err;
    o_resp_data      = '0;
    o_mem_address    = '0;
    o_mem_write_data = '0;
    o_memory_read    = (r_state == ST_RD) & ~i_rst;
    o_memory_write   = (r_state == ST_WR) & ~i_rst;
    if (r_state == ST_RD || r_state == ST_WT || r_state == ST_WR)
      o_mem_address = r_addr;
    if (r_state == ST_WR)
      o_mem_write_data = w_store;
    if (r_state == ST_RESP && !r_err && !r_write)
      o_resp_data = w_load;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array big-endian memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_signed = 1'b0;
  logic [63:0] i_req_address = '0;
  logic [63:0] i_req_write_data = '0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b1;
  logic [63:0] o_resp_data;
  logic        o_resp_error;
  logic [63:0] o_mem_address;
  logic [63:0] o_mem_write_data;
  logic        o_memory_read;
  logic        o_memory_write;
  logic [63:0] i_mem_read_data = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [63:0] pre_d = '0;

  int          lat, nrd, nwr, wr0;
  logic [63:0] d;
  logic        e;

  load_store_unit #(.MEM_SIZE(1024), .ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_size(i_req_size),
    .i_req_signed(i_req_signed), .i_req_address(i_req_address),
    .i_req_write_data(i_req_write_data),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_data(o_resp_data), .o_resp_error(o_resp_error),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .o_memory_read(o_memory_read), .o_memory_write(o_memory_write),
    .i_mem_read_data(i_mem_read_data)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous big-endian memory: read data valid the cycle after MemoryRead.
  always @(posedge i_clk) begin
    logic [63:0] idx;
    logic [63:0] tmp;
    if (pre_we)
      for (int k = 0; k < 8; k++) mem[pre_a + 10'(k)] = pre_d[63-8*k -: 8];
    if (o_memory_read) begin
      for (int k = 0; k < 8; k++) begin
        idx = o_mem_address + 64'(k);
        tmp[63-8*k -: 8] = (idx < 64'd1024) ? mem[idx[9:0]] : 8'h00;
      end
      i_mem_read_data <= tmp;
      rd_pulses++;
    end
    if (o_memory_write) begin
      for (int k = 0; k < 8; k++) begin
        idx = o_mem_address + 64'(k);
        if (idx < 64'd1024) mem[idx[9:0]] = o_mem_write_data[63-8*k -: 8];
      end
      wr_pulses++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [9:0] a, input logic [63:0] v);
    pre_a = a; pre_d = v; pre_we = 1'b1;
    @(posedge i_clk); #1;
    pre_we = 1'b0;
  endtask

  function automatic logic [63:0] mem_dw(input logic [9:0] a);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[63-8*k -: 8] = mem[a + 10'(k)];
    return v;
  endfunction

  // One request; hold>0 keeps RespReady low for that many cycles of RESP.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [63:0] a, input logic [63:0] wd,
                         input int hold, input logic [63:0] exp_hold,
                         output int o_lat, output logic [63:0] o_d, output logic o_e,
                         output int o_nrd, output int o_nwr);
    int guard;
    int rd0, w0;
    guard = 0;
    while (!o_req_ready && guard < 20) begin @(posedge i_clk); #1; guard++; end
    i_req_write = wr; i_req_size = sz; i_req_signed = sg;
    i_req_address = a; i_req_write_data = wd; i_req_valid = 1'b1;
    i_resp_ready = (hold == 0);
    rd0 = rd_pulses; w0 = wr_pulses;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    o_lat = 1;
    while (!o_resp_valid && o_lat < 20) begin @(posedge i_clk); #1; o_lat++; end
    o_d = o_resp_data; o_e = o_resp_error;
    o_nrd = rd_pulses - rd0; o_nwr = wr_pulses - w0;
    if (hold > 0) begin
      repeat (hold) begin @(posedge i_clk); #1; end
      chk({tag, "_hold_valid"}, 64'(o_resp_valid), 64'd1);
      chk({tag, "_hold_data"}, o_resp_data, exp_hold);
      i_resp_ready = 1'b1;
    end
    @(posedge i_clk); #1;
    chk({tag, "_back_idle"}, {62'd0, o_resp_valid, o_req_ready}, 64'd1);
  endtask

  initial begin
    // Reset and memory preset.
    preset(10'h018, 64'h0ffbea7deadbeeff);
    preset(10'h3f8, 64'h0000000000000080);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_outputs", {58'd0, o_req_ready, o_resp_valid, o_resp_error,
                        o_memory_read, o_memory_write, 1'b0}, 64'h20);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_ready", 64'(o_req_ready), 64'd1);
    chk("rst_resp_data", o_resp_data, 64'd0);
    chk("rst_mem_addr", o_mem_address, 64'd0);
    chk("rst_mem_wdata", o_mem_write_data, 64'd0);

    // Load word signed at 0x1C.
    run_req("lw1c", 1'b0, SZ_WORD, 1'b1, 64'h1c, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("lw1c_data", d, 64'hffffffffeadbeeff);
    chk("lw1c_err", 64'(e), 64'd0);
    chk("lw1c_lat", 64'(lat), 64'd3);
    chk("lw1c_rd", 64'(nrd), 64'd1);
    chk("lw1c_wr", 64'(nwr), 64'd0);

    // Load half unsigned at 0x19.
    run_req("lh19", 1'b0, SZ_HALF, 1'b0, 64'h19, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh19_err", 64'(e), 64'd1);
    chk("lh19_data", d, 64'd0);
    chk("lh19_lat", 64'(lat), 64'd1);
    chk("lh19_rd", 64'(nrd), 64'd0);
`else
    chk("lh19_err", 64'(e), 64'd0);
    chk("lh19_data", d, 64'h000000000000fbea);
    chk("lh19_lat", 64'(lat), 64'd3);
`endif

    // Load byte signed at 0x18 with RespReady held low for 3 cycles.
    run_req("lb18", 1'b0, SZ_BYTE, 1'b1, 64'h18, 64'd0, 3, 64'h0f, lat, d, e, nrd, nwr);
    chk("lb18_data", d, 64'h000000000000000f);
    chk("lb18_lat", 64'(lat), 64'd3);

    // Store byte 0xAB at 0x20 (read-modify-write), then read it back.
    run_req("sb20", 1'b1, SZ_BYTE, 1'b0, 64'h20, 64'h00000000000000ab, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("sb20_lat", 64'(lat), 64'd4);
    chk("sb20_rd", 64'(nrd), 64'd1);
    chk("sb20_wr", 64'(nwr), 64'd1);
    chk("sb20_resp", {d[62:0], e}, 64'd0);
    run_req("ld20a", 1'b0, SZ_DWORD, 1'b0, 64'h20, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("ld20a_data", d, 64'hab00000000000000);

    // Doubleword load crossing the top of memory.
    run_req("ld3fc", 1'b0, SZ_DWORD, 1'b0, 64'h3fc, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("ld3fc_err", 64'(e), 64'd1);
    chk("ld3fc_data", d, 64'd0);
    chk("ld3fc_lat", 64'(lat), 64'd1);
    chk("ld3fc_strobes", 64'(nrd + nwr), 64'd0);

    // Misaligned word signed at 0x1A.
    run_req("lw1a", 1'b0, SZ_WORD, 1'b1, 64'h1a, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw1a_err", 64'(e), 64'd1);
    chk("lw1a_lat", 64'(lat), 64'd1);
`else
    chk("lw1a_data", d, 64'hffffffffea7deadb);
    chk("lw1a_err", 64'(e), 64'd0);
`endif

    // Last byte in memory is in range; word at 0x3FD and wrapping address are not.
    run_req("lb3ff", 1'b0, SZ_BYTE, 1'b1, 64'h3ff, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("lb3ff_data", d, 64'hffffffffffffff80);
    chk("lb3ff_err", 64'(e), 64'd0);
    run_req("lw3fd", 1'b0, SZ_WORD, 1'b0, 64'h3fd, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("lw3fd_err", 64'(e), 64'd1);
    run_req("lbwrap", 1'b0, SZ_BYTE, 1'b0, 64'hffffffffffffffff, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("lbwrap_err", 64'(e), 64'd1);
    chk("lbwrap_rd", 64'(nrd), 64'd0);

    // Reset during WT of a byte store: no write, back to IDLE.
    wr0 = wr_pulses;
    i_req_write = 1'b1; i_req_size = SZ_BYTE; i_req_signed = 1'b0;
    i_req_address = 64'h28; i_req_write_data = 64'hcd; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("rstwt_busy", 64'(o_req_ready), 64'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("rstwt_idle", {62'd0, o_resp_valid, o_req_ready}, 64'd1);
    chk("rstwt_addr", o_mem_address, 64'd0);
    @(posedge i_clk); #1;
    chk("rstwt_nowrite", 64'(wr_pulses - wr0), 64'd0);
    chk("rstwt_mem", {56'd0, mem[10'h28]}, 64'd0);

    // Doubleword store after the aborted one, then readback.
    run_req("sd20", 1'b1, SZ_DWORD, 1'b0, 64'h20, 64'h1122334455667788, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("sd20_lat", 64'(lat), 64'd2);
    chk("sd20_rd", 64'(nrd), 64'd0);
    chk("sd20_wr", 64'(nwr), 64'd1);
    run_req("ld20b", 1'b0, SZ_DWORD, 1'b0, 64'h20, 64'd0, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("ld20b_data", d, 64'h1122334455667788);

    // Half store merge at 0x22 inside that doubleword.
    run_req("sh22", 1'b1, SZ_HALF, 1'b0, 64'h22, 64'hffffffffffffbeef, 0, 64'd0, lat, d, e, nrd, nwr);
    chk("sh22_lat", 64'(lat), 64'd4);
    chk("sh22_mem", mem_dw(10'h20), 64'h1122beef55667788);

    // Reset raised inside WR suppresses that edge's write.
    wr0 = wr_pulses;
    i_req_write = 1'b1; i_req_size = SZ_BYTE; i_req_signed = 1'b0;
    i_req_address = 64'h30; i_req_write_data = 64'hee; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("rstwr_strobe", 64'(o_memory_write), 64'd1);
    chk("rstwr_wdata", o_mem_write_data, 64'hee00000000000000);
    i_rst = 1'b1;
    #1;
    chk("rstwr_masked", 64'(o_memory_write), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("rstwr_nowrite", 64'(wr_pulses - wr0), 64'd0);
    chk("rstwr_mem", {56'd0, mem[10'h30]}, 64'd0);
    chk("rstwr_idle", 64'(o_req_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
